// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM state encoding, bus widths
// and the fault predicate used to refuse an access before it reaches memory.
package mem_stage_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,  // no access in flight
        ST_REQ  = 2'b01,  // request presented, memory has not accepted yet
        ST_WAIT = 2'b10   // accepted, waiting for done
    } state_t;

    // A word access must be even-aligned and cannot be a load and a store at once.
    function automatic logic access_fault(input logic rd, input logic wr, input logic addr_lsb);
        return addr_lsb | (rd & wr);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port between the memory stage (master) and the data memory (slave).
//   req   : master -> slave, access request
//   wr    : master -> slave, 1 = write, 0 = read; valid with req
//   addr  : master -> slave, access address; valid with req
//   wdata : master -> slave, write data; valid with req & wr
//   stall : slave -> master, request in this cycle not accepted
//   done  : slave -> master, access complete; rdata valid for reads
//   rdata : slave -> master, read data
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              stall;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, addr, wdata,
        input  stall, done, rdata
    );

    modport slave (
        input  req, wr, addr, wdata,
        output stall, done, rdata
    );

endinterface

// File: rtl/mem_stage_wait_cnt.sv
// Wait-cycle counter for the memory stage.
//   clk, rst : clock and synchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count one cycle
//   tc       : counter equals TIMEOUT-1, i.e. this is the last allowed wait cycle
module mem_wait_cnt #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: turns one load/store per instruction into a single
// access on a stalling req/accept/done data-memory port, stalls the pipeline
// until the access completes and registers load data for writeback and the
// M->X forwarding path.
//   clk, rst    : clock and synchronous active-high reset
//   valid_m     : instruction present in MEM this cycle
//   mem_read    : instruction is a load
//   mem_write   : instruction is a store (both set is illegal)
//   addr_m      : effective address from the EX/MEM latch
//   wrt_data_m  : store data from the EX/MEM latch
//   dm          : data-memory port (master side)
//   read_data_m : registered load result
//   stall_m     : hold IF..EX and the EX/MEM latch this cycle
//   err         : sticky error (misaligned, illegal op, timeout)
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16,  // max wait cycles after acceptance (>= 2)
    parameter int CNT_W   = 5    // must hold TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_m,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr_m,
    input  logic [DATA_W-1:0] wrt_data_m,
    mem_stage_if.master       dm,
    output logic [DATA_W-1:0] read_data_m,
    output logic              stall_m,
    output logic              err
);

    state_t state;
    state_t state_nxt;
    logic   access;
    logic   req;
    logic   stall;
    logic   err_set;
    logic   load_cap;
    logic   cnt_clr;
    logic   cnt_en;
    logic   cnt_tc;

    // Once err is up the stage refuses all work so the pipeline can drain.
    assign access = valid_m & (mem_read | mem_write) & ~err;

    mem_wait_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        stall     = 1'b0;
        err_set   = 1'b0;
        load_cap  = 1'b0;
        cnt_clr   = 1'b1;
        cnt_en    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (access) begin
                    if (access_fault(mem_read, mem_write, addr_m[0])) begin
                        err_set = 1'b1;
                    end else begin
                        req       = 1'b1;
                        stall     = 1'b1;
                        state_nxt = dm.stall ? ST_REQ : ST_WAIT;
                    end
                end
            end

            ST_REQ: begin
                // Address and data come straight from the held EX/MEM latch,
                // so re-driving them is free.
                req   = 1'b1;
                stall = 1'b1;
                if (!dm.stall) begin
                    state_nxt = ST_WAIT;
                end
            end

            ST_WAIT: begin
                cnt_clr = 1'b0;
                cnt_en  = 1'b1;
                // done is checked first: it wins over stall and over the
                // timeout landing in the same cycle.
                if (dm.done) begin
                    load_cap  = mem_read;
                    cnt_clr   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cnt_tc) begin
                    err_set   = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // While reset is held the port and the pipeline see an idle stage,
        // whatever state the flops were left in.
        if (rst) begin
            req   = 1'b0;
            stall = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            read_data_m <= '0;
            err         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_cap) begin
                read_data_m <= dm.rdata;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    assign dm.req   = req;
    assign dm.wr    = mem_write;
    assign dm.addr  = addr_m;
    assign dm.wdata = wrt_data_m;
    assign stall_m  = stall;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage. A pipeline/memory driver plays both the
// EX/MEM latch and a data memory with a programmable number of accept stalls
// and wait cycles; it records what the stage did per instruction. A
// transaction-level model predicts the same summary from the access rules.
module tb_mem_stage;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_m;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] addr_m;
    logic [15:0] wrt_data_m;
    logic [15:0] read_data_m;
    logic        stall_m;
    logic        err;

    mem_stage_if dm();

    mem_stage #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_m     (valid_m),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .addr_m      (addr_m),
        .wrt_data_m  (wrt_data_m),
        .dm          (dm),
        .read_data_m (read_data_m),
        .stall_m     (stall_m),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          req_cyc;    // cycles with dm.req high
        int          stall_cyc;  // cycles with stall_m high
        int          cycles;     // cycles the instruction spent in MEM
        int          bus_bad;    // req cycles with wrong addr/wr/wdata
        logic        req_first;  // request issued in the instruction's first cycle
        logic [15:0] rdata;      // read_data_m after the instruction left
        logic        err;        // err after the instruction left
        logic        hung;       // stage never released the pipeline
    } obs_t;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] m_rdata;
    logic        m_err;

    function automatic string fmt(input obs_t o);
        return $sformatf("req=%0d stall=%0d cyc=%0d bus_bad=%0d first=%0b rdata=%h err=%b hung=%b",
                         o.req_cyc, o.stall_cyc, o.cycles, o.bus_bad, o.req_first, o.rdata, o.err, o.hung);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        valid_m  = 1'b0;
        dm.stall = 1'b0;
        dm.done  = 1'b0;
        step();
        rst     = 1'b0;
        m_rdata = 16'h0000;
        m_err   = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_m = 1'b0;
        dm.done = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Reference: what one instruction should do, from the access rules.
    task automatic model_access(input logic rd, input logic wr, input logic [15:0] addr,
                                input logic [15:0] rdata, input int n_stall, input int n_wait,
                                output obs_t e);
        int wait_cycles;
        e = '0;
        e.cycles = 1;
        if ((rd || wr) && !m_err) begin
            if (addr[0] || (rd && wr)) begin
                m_err = 1'b1;
            end else begin
                e.req_cyc   = n_stall + 1;
                e.req_first = 1'b1;
                if (n_wait <= TIMEOUT - 1) begin
                    wait_cycles = n_wait + 1;
                    if (rd) m_rdata = rdata;
                end else begin
                    wait_cycles = TIMEOUT;
                    m_err       = 1'b1;
                end
                // The final wait cycle (done or timeout) releases the stall.
                e.stall_cyc = n_stall + wait_cycles;
                e.cycles    = n_stall + 1 + wait_cycles;
            end
        end
        e.rdata = m_rdata;
        e.err   = m_err;
    endtask

    // Presents one instruction and plays the memory: the first n_stall
    // requests are refused, then done arrives after n_wait wait cycles.
    // The instruction leaves MEM on the first cycle stall_m is low.
    task automatic drive_access(input logic rd, input logic wr, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [15:0] rdata,
                                input int n_stall, input int n_wait, output obs_t o);
        int   stalls_given;
        int   wait_idx;
        logic accepted;
        logic fin;
        o            = '0;
        stalls_given = 0;
        wait_idx     = 0;
        accepted     = 1'b0;
        fin          = 1'b0;
        valid_m      = 1'b1;
        mem_read     = rd;
        mem_write    = wr;
        addr_m       = addr;
        wrt_data_m   = wdata;
        for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
            if (!accepted) begin
                dm.stall = (stalls_given < n_stall);
                dm.done  = 1'($urandom_range(0, 1));  // spurious, must be ignored
                dm.rdata = 16'($urandom);
            end else begin
                dm.done  = (wait_idx == n_wait);
                dm.stall = 1'($urandom_range(0, 1));  // done must win over it
                dm.rdata = dm.done ? rdata : 16'($urandom);
                wait_idx++;
            end
            @(negedge clk);
            if (dm.req === 1'b1) begin
                o.req_cyc = o.req_cyc + 1;
                if (cyc == 0) o.req_first = 1'b1;
                if (dm.addr !== addr || dm.wr !== wr || (wr && dm.wdata !== wdata))
                    o.bus_bad = o.bus_bad + 1;
                if (dm.stall) stalls_given++;
                else accepted = 1'b1;
            end
            if (stall_m === 1'b1) o.stall_cyc = o.stall_cyc + 1;
            else fin = 1'b1;
            o.cycles = o.cycles + 1;
            step();
        end
        dm.done = 1'b0;
        o.hung  = !fin;
        o.rdata = read_data_m;
        o.err   = err;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        valid_m = 1'b0;
        step();
        step();
        @(negedge clk);
        total++;
        if ({dm.req, stall_m, err, read_data_m} !== 19'h0) begin
            bad++;
            $display("FAIL reset_held: req=%b stall=%b err=%b rdata=%h want all 0",
                     dm.req, stall_m, err, read_data_m);
        end
        step();
        rst     = 1'b0;
        m_rdata = 16'h0000;
        m_err   = 1'b0;
        @(negedge clk);
        total++;
        if ({dm.req, stall_m, err, read_data_m} !== 19'h0) begin
            bad++;
            $display("FAIL reset_release: req=%b stall=%b err=%b rdata=%h want all 0",
                     dm.req, stall_m, err, read_data_m);
        end
        step();
    endtask

    task automatic test_zero_wait_load();
        obs_t o, e;
        model_access(1'b1, 1'b0, 16'h0010, 16'hBEEF, 0, 0, e);
        drive_access(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 0, 0, o);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL zero_wait_load: got %s want %s", fmt(o), fmt(e));
        end
        idle(1);
    endtask

    task automatic test_accept_stall();
        obs_t o, e;
        model_access(1'b0, 1'b1, 16'h0020, 16'h0000, 3, 2, e);
        drive_access(1'b0, 1'b1, 16'h0020, 16'h1234, 16'h5555, 3, 2, o);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL accept_stall_store: got %s want %s", fmt(o), fmt(e));
        end
        idle(1);
    endtask

    task automatic test_random();
        obs_t o, e;
        for (int i = 0; i < 25; i++) begin
            logic [15:0] a = 16'($urandom);
            logic [15:0] wd = 16'($urandom);
            logic [15:0] rd_val = 16'($urandom);
            int op = int'($urandom_range(0, 3));
            int ns = int'($urandom_range(0, 3));
            int nw = int'($urandom_range(0, 5));
            logic rd = (op == 0 || op == 1);
            logic wr = (op == 2);
            a[0] = 1'b0;
            model_access(rd, wr, a, rd_val, ns, nw, e);
            drive_access(rd, wr, a, wd, rd_val, ns, nw, o);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL random_%0d op=%0d: got %s want %s", i, op, fmt(o), fmt(e));
            end
            if ($urandom_range(0, 2) == 0) idle(1);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2, e1, e2;
        model_access(1'b1, 1'b0, 16'h0002, 16'hA1A1, 0, 1, e1);
        drive_access(1'b1, 1'b0, 16'h0002, 16'h0000, 16'hA1A1, 0, 1, o1);
        model_access(1'b1, 1'b0, 16'h0004, 16'hB2B2, 1, 0, e2);
        drive_access(1'b1, 1'b0, 16'h0004, 16'h0000, 16'hB2B2, 1, 0, o2);
        total++;
        if (o1 !== e1) begin
            bad++;
            $display("FAIL back_to_back_first: got %s want %s", fmt(o1), fmt(e1));
        end
        total++;
        if (o2 !== e2) begin
            bad++;
            $display("FAIL back_to_back_second: got %s want %s", fmt(o2), fmt(e2));
        end
        idle(1);
    endtask

    task automatic test_rst_in_wait();
        obs_t o, e;
        // Leave a non-zero load result so the clear is visible.
        model_access(1'b1, 1'b0, 16'h0030, 16'h7777, 0, 0, e);
        drive_access(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h7777, 0, 0, o);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL pre_rst_load: got %s want %s", fmt(o), fmt(e));
        end
        // Issue a load, let it be accepted, then reset while it waits.
        valid_m  = 1'b1;
        mem_read = 1'b1;
        mem_write = 1'b0;
        addr_m   = 16'h0040;
        dm.stall = 1'b0;
        dm.done  = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({dm.req, stall_m} !== 2'b00) begin
            bad++;
            $display("FAIL rst_in_wait_held: req=%b stall=%b want 0 0", dm.req, stall_m);
        end
        step();
        rst      = 1'b0;
        valid_m  = 1'b0;
        dm.done  = 1'b1;  // late response for the discarded access
        dm.rdata = 16'hDEAD;
        m_rdata  = 16'h0000;
        m_err    = 1'b0;
        @(negedge clk);
        total++;
        if ({dm.req, stall_m, read_data_m} !== 18'h0) begin
            bad++;
            $display("FAIL rst_in_wait_after: req=%b stall=%b rdata=%h want 0 0 0000",
                     dm.req, stall_m, read_data_m);
        end
        step();
        dm.done = 1'b0;
        total++;
        if ({read_data_m, err} !== 17'h0) begin
            bad++;
            $display("FAIL rst_late_done: rdata=%h err=%b want 0000 0", read_data_m, err);
        end
        model_access(1'b1, 1'b0, 16'h0042, 16'h0F0F, 0, 1, e);
        drive_access(1'b1, 1'b0, 16'h0042, 16'h0000, 16'h0F0F, 0, 1, o);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL post_rst_load: got %s want %s", fmt(o), fmt(e));
        end
        idle(1);
    endtask

    task automatic test_misaligned();
        obs_t o, e;
        model_access(1'b1, 1'b0, 16'h0011, 16'h0000, 0, 0, e);
        drive_access(1'b1, 1'b0, 16'h0011, 16'h0000, 16'h9999, 0, 0, o);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL misaligned: got %s want %s", fmt(o), fmt(e));
        end
        for (int i = 0; i < 3; i++) begin
            logic [15:0] a = 16'($urandom);
            a[0] = 1'b0;
            model_access(1'b1, 1'b0, a, 16'h4321, 0, 0, e);
            drive_access(1'b1, 1'b0, a, 16'h0000, 16'h4321, 0, 0, o);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL err_sticky_%0d: got %s want %s", i, fmt(o), fmt(e));
            end
        end
        do_reset();
    endtask

    task automatic test_illegal_op();
        obs_t o, e;
        model_access(1'b1, 1'b1, 16'h0050, 16'h0000, 0, 0, e);
        drive_access(1'b1, 1'b1, 16'h0050, 16'h1111, 16'h2222, 0, 0, o);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL illegal_op: got %s want %s", fmt(o), fmt(e));
        end
        do_reset();
    endtask

    task automatic test_timeout();
        obs_t o, e;
        // done on the last allowed wait cycle still completes normally
        model_access(1'b1, 1'b0, 16'h0060, 16'hC0DE, 1, TIMEOUT - 1, e);
        drive_access(1'b1, 1'b0, 16'h0060, 16'h0000, 16'hC0DE, 1, TIMEOUT - 1, o);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL timeout_edge_done: got %s want %s", fmt(o), fmt(e));
        end
        idle(1);
        model_access(1'b1, 1'b0, 16'h0062, 16'h0000, 0, 100, e);
        drive_access(1'b1, 1'b0, 16'h0062, 16'h0000, 16'h0000, 0, 100, o);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL timeout: got %s want %s", fmt(o), fmt(e));
        end
        model_access(1'b0, 1'b1, 16'h0064, 16'h0000, 0, 0, e);
        drive_access(1'b0, 1'b1, 16'h0064, 16'hAAAA, 16'h0000, 0, 0, o);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL after_timeout: got %s want %s", fmt(o), fmt(e));
        end
        do_reset();
    endtask

    initial begin
        rst        = 1'b1;
        valid_m    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr_m     = 16'h0000;
        wrt_data_m = 16'h0000;
        dm.stall   = 1'b0;
        dm.done    = 1'b0;
        dm.rdata   = 16'h0000;
        m_rdata    = 16'h0000;
        m_err      = 1'b0;
        #1;
        test_reset();
        test_zero_wait_load();
        test_accept_stall();
        test_random();
        test_back_to_back();
        test_rst_in_wait();
        test_misaligned();
        test_illegal_op();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
